// File: rtl/slice_config_loader.sv
// slice_config_loader: assembles a W-bit word stream into one slice
// configuration bundle (LUT config, carry-chain use bit, inter-LUT mux) and
// pulses cen once per committed frame.
// Optional build macro: CFG_PARITY_EN adds in_parity (even parity per word)
// and the ERR state; without it err is constant 0 and ERR is unreachable.
module slice_config_loader #(
  parameter int S_XX_BASE = 4,
  parameter int CFG_SIZE  = 2**S_XX_BASE + 1,
  parameter int NUM_LUTS  = 4,
  parameter int MUX_LVLS  = $clog2(NUM_LUTS),
  parameter int W         = 8
) (
  input  logic                          cclk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [W-1:0]                  in_data,
  input  logic                          in_valid,
`ifdef CFG_PARITY_EN
  input  logic                          in_parity,
`endif
  output logic                          in_ready,
  output logic [NUM_LUTS*2*CFG_SIZE-1:0] cfg_luts,
  output logic                          cfg_use_cc,
  output logic [MUX_LVLS-1:0]           cfg_mux,
  output logic                          cen,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int LUT_BITS   = NUM_LUTS*2*CFG_SIZE;
  localparam int FRAME_BITS = LUT_BITS + 1 + MUX_LVLS;
  localparam int NUM_WORDS  = (FRAME_BITS + W - 1) / W;
  localparam int CW         = $clog2(NUM_WORDS + 1);

  typedef enum logic [2:0] {IDLE, LOAD, COMMIT, DONE, ERR} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [FRAME_BITS-1:0] asm_q;
  logic [FRAME_BITS-1:0] full;
  logic                  hs, last, par_ok;

  assign hs   = in_valid && in_ready;
  assign last = (cnt == CW'(NUM_WORDS-1));

`ifdef CFG_PARITY_EN
  assign par_ok = ~(^{in_parity, in_data});
`else
  assign par_ok = 1'b1;
`endif

  // Assembly register with the current word dropped into slot cnt; bits of
  // the final word beyond FRAME_BITS simply have no destination.
  always_comb begin
    full = asm_q;
    for (int i = 0; i < FRAME_BITS; i++)
      if (cnt == CW'(i / W)) full[i] = in_data[i % W];
  end

  // Frame FSM; all handshake/status outputs are registered with the state.
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      asm_q      <= '0;
      in_ready   <= 1'b0;
      cen        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cfg_luts   <= '0;
      cfg_use_cc <= 1'b0;
      cfg_mux    <= '0;
    end else begin
      cen <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= LOAD;
            cnt      <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          // start is deliberately ignored here, including on the final word
          if (hs) begin
            if (!par_ok) begin
              state    <= ERR;
              err      <= 1'b1;
              in_ready <= 1'b0;
              busy     <= 1'b0;
            end else begin
              asm_q <= full;
              cnt   <= cnt + 1'b1;
              if (last) begin
                cfg_luts   <= full[LUT_BITS-1:0];
                cfg_use_cc <= full[LUT_BITS];
                cfg_mux    <= full[LUT_BITS+1 +: MUX_LVLS];
                state      <= COMMIT;
                in_ready   <= 1'b0;
                cen        <= 1'b1;
              end
            end
          end
        end
        COMMIT: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slice_config_loader.sv
// Directed bench for slice_config_loader (default parameters: 18 words of
// 8 bits, 139-bit frame). Parity steps are present only with CFG_PARITY_EN.
module tb_slice_config_loader;

  localparam int FB = 139;
  localparam int NW = 18;

  logic         cclk = 1'b0;
  logic         rst_n, start, in_valid, in_parity;
  logic [7:0]   in_data;
  logic         in_ready, cfg_use_cc, cen, busy, done, err;
  logic [135:0] cfg_luts;
  logic [1:0]   cfg_mux;

  int checks = 0;
  int errors = 0;
  int cen_cnt = 0;
  int base;

  logic [7:0]    wa [NW];
  logic [7:0]    wb [NW];
  logic [FB-1:0] exp_a, exp_b;

  slice_config_loader dut (
    .cclk      (cclk),
    .rst_n     (rst_n),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef CFG_PARITY_EN
    .in_parity (in_parity),
`endif
    .in_ready  (in_ready),
    .cfg_luts  (cfg_luts),
    .cfg_use_cc(cfg_use_cc),
    .cfg_mux   (cfg_mux),
    .cen       (cen),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 cclk = ~cclk;

  // count commit strobes just after each rising edge
  always @(posedge cclk) begin
    #1;
    if (cen === 1'b1) cen_cnt++;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // LSB-first packing: bit k of word n is frame bit n*8+k
  function automatic logic [FB-1:0] pack(input logic [7:0] w [NW]);
    logic [FB-1:0] f;
    f = '0;
    for (int n = 0; n < NW; n++)
      for (int k = 0; k < 8; k++) begin
        int idx;
        idx = n*8 + k;
        if (idx < FB) f[idx] = w[n][k];
      end
    return f;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(negedge cclk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d);
    in_data   = d;
    in_parity = ^d;
    in_valid  = 1'b1;
    @(negedge cclk);
    in_valid  = 1'b0;
  endtask

  task automatic check_cfg(input string tag, input logic [FB-1:0] f);
    check({tag, "_luts"}, cfg_luts, f[135:0]);
    check({tag, "_cc"}, cfg_use_cc, f[136]);
    check({tag, "_mux"}, cfg_mux, f[138:137]);
  endtask

  initial begin
    for (int n = 0; n < NW; n++) begin
      wa[n] = 8'(n);
      wb[n] = (n == NW-1) ? 8'hFF : (8'h5A ^ 8'(n));
    end
    exp_a = pack(wa);
    exp_b = pack(wb);

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_parity = 1'b0;
    repeat (2) @(negedge cclk);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cen", cen, 0);
    check_cfg("rst", '0);
    rst_n = 1'b1;
    @(negedge cclk);

    // frame A with continuous valid
    do_start();
    check("a_busy", busy, 1);
    check("a_ready", in_ready, 1);
    for (int n = 0; n < NW; n++) begin
      if (n == NW-1) check("a_nocen_early", cen_cnt, 0);
      send_word(wa[n]);
    end
    check("a_cen", cen, 1);
    check("a_cen_cnt", cen_cnt, 1);
    check("a_lut0", cfg_luts[7:0], 8'h00);
    check("a_lut1", cfg_luts[15:8], 8'h01);
    check("a_cc", cfg_use_cc, 1);
    check("a_mux", cfg_mux, 2'b00);
    check_cfg("a", exp_a);
    check("a_commit_ready", in_ready, 0);
    @(negedge cclk);
    check("a_cen_low", cen, 0);
    check("a_done", done, 1);
    check("a_busy_low", busy, 0);
    repeat (3) @(negedge cclk);
    check("a_cen_once", cen_cnt, 1);

    // frame A again with valid gaps carrying garbage data
    base = cen_cnt;
    do_start();
    check("t_done_clr", done, 0);
    for (int n = 0; n < NW; n++) begin
      send_word(wa[n]);
      if (n < NW-1) begin
        in_data = 8'hAA;
        @(negedge cclk);
      end
      if (n == NW-2) check("t_nocen_early", cen_cnt, base);
    end
    check("t_cen", cen, 1);
    check_cfg("t", exp_a);
    @(negedge cclk);
    check("t_cen_once", cen_cnt, base + 1);

    // partial frame B then stall: outputs keep frame A
    base = cen_cnt;
    do_start();
    for (int n = 0; n < 10; n++) send_word(8'h80 | 8'(n));
    repeat (5) @(negedge cclk);
    check_cfg("stall", exp_a);
    check("stall_cen", cen_cnt, base);
    check("stall_busy", busy, 1);
    check("stall_ready", in_ready, 1);

    // asynchronous reset mid-load, away from any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", in_ready, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check_cfg("arst", '0);
    @(negedge cclk);
    rst_n = 1'b1;
    repeat (2) @(negedge cclk);
    check("arst_nocen", cen_cnt, base);
    check("arst_idle_ready", in_ready, 0);

    // frame B: last word 0xFF, start pulses mid-load and on the final word
    base = cen_cnt;
    do_start();
    for (int n = 0; n < NW; n++) begin
      if (n == 5 || n == NW-1) start = 1'b1;
      send_word(wb[n]);
      start = 1'b0;
    end
    check("b_cen", cen, 1);
    check("b_lut0", cfg_luts[7:0], 8'h5A);
    check("b_cc", cfg_use_cc, 1);
    check("b_mux", cfg_mux, 2'b11);
    check_cfg("b", exp_b);
    @(negedge cclk);
    check("b_done", done, 1);
    check("b_busy", busy, 0);
    check("b_ready", in_ready, 0);
    repeat (2) @(negedge cclk);
    check("b_cen_once", cen_cnt, base + 1);

`ifdef CFG_PARITY_EN
    // bad parity on word 4 aborts the frame
    base = cen_cnt;
    do_start();
    for (int n = 0; n < 4; n++) send_word(wa[n]);
    in_data = wa[4]; in_parity = ~(^wa[4]); in_valid = 1'b1;
    @(negedge cclk);
    in_valid = 1'b0;
    check("p_err", err, 1);
    check("p_ready", in_ready, 0);
    repeat (3) @(negedge cclk);
    check("p_nocen", cen_cnt, base);
    check_cfg("p", exp_b);
    do_start();
    check("p_err_clr", err, 0);
    for (int n = 0; n < NW; n++) send_word(wa[n]);
    check("p_cen", cen, 1);
    check_cfg("p_good", exp_a);
    @(negedge cclk);
    check("p_cen_once", cen_cnt, base + 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
